// File: rtl/fmps_test_link_checker.sv
// FMPS test link receive checker: parses header + data word packets from the Aurora
// AXI4-Stream, reports framing/payload results and keeps saturating packet counters.
module fmps_test_link_checker #(
  parameter int          INDEX_WIDTH     = 5,
  parameter int          INDEX_START_BIT = 10,
  parameter logic [15:0] MAGIC           = 16'hB6CF,
  parameter int          NUM_DATA_WORDS  = 1,
  parameter logic [15:0] DATA_PATTERN    = 16'hCACA,
  parameter int          COUNT_WIDTH     = 16
) (
  input  logic                         auroraUserClk,
  input  logic                         auroraUserRst_n,
  input  logic                         newCycleStrobe,
  input  logic                         TVALID,
  input  logic [31:0]                  TDATA,
  input  logic                         TLAST,
  output logic                         TREADY,
  output logic                         packetStrobe,
  output logic [INDEX_WIDTH-1:0]       packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0] packetData,
  output logic                         statusStrobe,
  output logic [1:0]                   statusCode,
  output logic [4:0]                   payloadErrors,
  output logic [COUNT_WIDTH-1:0]       goodCount,
  output logic [COUNT_WIDTH-1:0]       badCount,
  output logic [7:0]                   lastCyclePackets
);

  localparam int CNT_W = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_DATA_WORDS - 1);

  localparam logic [1:0] ST_HEADER  = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_REPORT  = 2'd3;

  localparam logic [1:0] CODE_OK     = 2'd0;
  localparam logic [1:0] CODE_MAGIC  = 2'd1;
  localparam logic [1:0] CODE_EARLY  = 2'd2;
  localparam logic [1:0] CODE_NOLAST = 2'd3;

  logic [1:0]                   stateQ, stateD;
  logic [1:0]                   codeQ, codeD;
  logic [CNT_W-1:0]             wordCntQ, wordCntD;
  logic [INDEX_WIDTH-1:0]       indexQ, indexD;
  logic [32*NUM_DATA_WORDS-1:0] dataQ, dataD;
  logic                         treadyQ;
  logic [7:0]                   expCycleQ, cycleGoodQ, lastCycleQ;
  logic [COUNT_WIDTH-1:0]       goodCountQ, badCountQ;

  logic       beat, reportActive, reportOk, goodNow, badNow;
  logic [7:0] expCycleNow;
  logic [31:0] word0;
  logic [4:0] payloadErr;

  assign beat = TVALID && treadyQ;

  always_comb begin
    stateD   = stateQ;
    codeD    = codeQ;
    wordCntD = wordCntQ;
    indexD   = indexQ;
    dataD    = dataQ;
    case (stateQ)
      ST_HEADER: begin
        if (beat) begin
          wordCntD = '0;
          if (TDATA[31:16] == MAGIC) begin
            indexD = TDATA[INDEX_START_BIT +: INDEX_WIDTH];
            if (TLAST) begin
              codeD  = CODE_EARLY;
              stateD = ST_REPORT;
            end else begin
              stateD = ST_DATA;
            end
          end else begin
            codeD  = CODE_MAGIC;
            stateD = TLAST ? ST_REPORT : ST_DISCARD;
          end
        end
      end
      ST_DATA: begin
        if (beat) begin
          for (int k = 0; k < NUM_DATA_WORDS; k++) begin
            if (wordCntQ == CNT_W'(k)) dataD[k*32 +: 32] = TDATA;
          end
          if (wordCntQ == LAST_WORD) begin
            codeD  = TLAST ? CODE_OK : CODE_NOLAST;
            stateD = TLAST ? ST_REPORT : ST_DISCARD;
          end else if (TLAST) begin
            codeD  = CODE_EARLY;
            stateD = ST_REPORT;
          end else begin
            wordCntD = wordCntQ + 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (beat && TLAST) stateD = ST_REPORT;
      end
      default: stateD = ST_HEADER;
    endcase
  end

  // A packet reported in the same clock as a cycle strobe belongs to the new cycle.
  assign expCycleNow  = newCycleStrobe ? expCycleQ + 8'd1 : expCycleQ;
  assign reportActive = (stateQ == ST_REPORT);
  assign reportOk     = reportActive && (codeQ == CODE_OK);
  assign word0        = dataQ[31:0];

  always_comb begin
    payloadErr = '0;
    if (reportOk) begin
      payloadErr = {word0[31], word0[30], word0[29],
                    word0[28:24] != 5'(indexQ),
                    (word0[23:8] != DATA_PATTERN) || (word0[7:0] != expCycleNow)};
    end
  end

  assign goodNow = reportOk && (payloadErr == 5'd0);
  assign badNow  = reportActive && !goodNow;

  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserRst_n) begin
      stateQ     <= ST_HEADER;
      codeQ      <= CODE_OK;
      wordCntQ   <= '0;
      indexQ     <= '0;
      dataQ      <= '0;
      treadyQ    <= 1'b0;
      expCycleQ  <= 8'd0;
      cycleGoodQ <= 8'd0;
      lastCycleQ <= 8'd0;
      goodCountQ <= '0;
      badCountQ  <= '0;
    end else begin
      stateQ    <= stateD;
      codeQ     <= codeD;
      wordCntQ  <= wordCntD;
      indexQ    <= indexD;
      dataQ     <= dataD;
      treadyQ   <= (stateD != ST_REPORT);
      expCycleQ <= expCycleNow;
      if (goodNow && (goodCountQ != '1)) goodCountQ <= goodCountQ + 1'b1;
      if (badNow && (badCountQ != '1)) badCountQ <= badCountQ + 1'b1;
      if (newCycleStrobe) begin
        lastCycleQ <= cycleGoodQ;
        cycleGoodQ <= goodNow ? 8'd1 : 8'd0;
      end else if (goodNow && (cycleGoodQ != 8'hFF)) begin
        cycleGoodQ <= cycleGoodQ + 8'd1;
      end
    end
  end

  assign TREADY           = treadyQ;
  assign packetStrobe     = reportOk;
  assign statusStrobe     = reportActive;
  assign statusCode       = reportActive ? codeQ : 2'd0;
  assign packetIndex      = indexQ;
  assign packetData       = dataQ;
  assign payloadErrors    = payloadErr;
  assign goodCount        = goodCountQ;
  assign badCount         = badCountQ;
  assign lastCyclePackets = lastCycleQ;

endmodule

// File: tb/tb_fmps_test_link_checker.sv
// Directed self-checking bench for fmps_test_link_checker with hand-computed expectations.
module tb_fmps_test_link_checker;

  logic        auroraUserClk;
  logic        auroraUserRst_n;
  logic        newCycleStrobe;
  logic        TVALID;
  logic [31:0] TDATA;
  logic        TLAST;
  logic        TREADY;
  logic        packetStrobe;
  logic [4:0]  packetIndex;
  logic [31:0] packetData;
  logic        statusStrobe;
  logic [1:0]  statusCode;
  logic [4:0]  payloadErrors;
  logic [15:0] goodCount;
  logic [15:0] badCount;
  logic [7:0]  lastCyclePackets;

  int testsRun  = 0;
  int failCount = 0;
  int statusCnt = 0;
  int pktCnt    = 0;
  int savedStatusCnt;

  fmps_test_link_checker dut (
    .auroraUserClk   (auroraUserClk),
    .auroraUserRst_n (auroraUserRst_n),
    .newCycleStrobe  (newCycleStrobe),
    .TVALID          (TVALID),
    .TDATA           (TDATA),
    .TLAST           (TLAST),
    .TREADY          (TREADY),
    .packetStrobe    (packetStrobe),
    .packetIndex     (packetIndex),
    .packetData      (packetData),
    .statusStrobe    (statusStrobe),
    .statusCode      (statusCode),
    .payloadErrors   (payloadErrors),
    .goodCount       (goodCount),
    .badCount        (badCount),
    .lastCyclePackets(lastCyclePackets)
  );

  initial auroraUserClk = 1'b0;
  always #5 auroraUserClk = ~auroraUserClk;

  // Strobe tally sampled mid-cycle, away from the active edge.
  always @(negedge auroraUserClk) begin
    if (statusStrobe === 1'b1) statusCnt++;
    if (packetStrobe === 1'b1) pktCnt++;
  end

  function automatic logic [31:0] mkHdr(input logic [4:0] idx);
    return {16'hB6CF, 1'b0, idx, 10'b0};
  endfunction

  function automatic logic [31:0] mkData(input logic [4:0] idx, input logic [7:0] cyc);
    return {3'b000, idx, 16'hCACA, cyc};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge auroraUserClk);
    #1;
  endtask

  // Called and returning at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    int waitCycles;
    TVALID = 1'b1;
    TDATA  = d;
    TLAST  = l;
    waitCycles = 0;
    forever begin
      @(negedge auroraUserClk);
      if (TREADY === 1'b1) break;
      waitCycles++;
      if (waitCycles > 100) begin
        testsRun++;
        failCount++;
        $error("[TB] FAIL tready_timeout: observed TREADY %0b, expected 1", TREADY);
        break;
      end
    end
    @(posedge auroraUserClk);
    #1;
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  task automatic sendPacket(input logic [4:0] hIdx, input logic [31:0] d);
    applyStimulus(mkHdr(hIdx), 1'b0);
    applyStimulus(d, 1'b1);
  endtask

  task automatic pulseCycle();
    newCycleStrobe = 1'b1;
    @(posedge auroraUserClk);
    #1;
    newCycleStrobe = 1'b0;
  endtask

  initial begin
    auroraUserRst_n = 1'b0;
    newCycleStrobe  = 1'b0;
    TVALID          = 1'b0;
    TDATA           = 32'd0;
    TLAST           = 1'b0;
    idle(3);

    checkOutput("reset_tready", TREADY, 0);
    checkOutput("reset_status", statusStrobe, 0);
    checkOutput("reset_good", goodCount, 0);
    checkOutput("reset_bad", badCount, 0);
    checkOutput("reset_lastCycle", lastCyclePackets, 0);
    checkOutput("reset_data", packetData, 0);

    auroraUserRst_n = 1'b1;
    idle(1);
    checkOutput("tready_after_reset", TREADY, 1);

    // Eight good packets in cycle 1
    pulseCycle();
    applyStimulus(mkHdr(5'd1), 1'b0);
    applyStimulus(mkData(5'd1, 8'd1), 1'b1);
    checkOutput("p1_statusStrobe", statusStrobe, 1);
    checkOutput("p1_packetStrobe", packetStrobe, 1);
    checkOutput("p1_tready_low", TREADY, 0);
    checkOutput("p1_code", statusCode, 0);
    checkOutput("p1_errors", payloadErrors, 0);
    checkOutput("p1_index", packetIndex, 1);
    checkOutput("p1_data", packetData, 32'h01CACA01);
    idle(1);
    checkOutput("p1_tready_back", TREADY, 1);
    checkOutput("p1_status_gone", statusStrobe, 0);
    for (int i = 2; i <= 8; i++) begin
      sendPacket(5'(i), mkData(5'(i), 8'd1));
      checkOutput("t1_code", statusCode, 0);
    end
    idle(1);
    checkOutput("t1_pktCnt", pktCnt, 8);
    checkOutput("t1_statusCnt", statusCnt, 8);
    checkOutput("t1_good", goodCount, 8);
    checkOutput("t1_bad", badCount, 0);
    pulseCycle();
    checkOutput("t1_lastCycle", lastCyclePackets, 8);

    // Bad magic, expected cycle is now 2
    applyStimulus(32'hDEAD0400, 1'b0);
    applyStimulus(mkData(5'd1, 8'd2), 1'b1);
    checkOutput("t2_strobe", statusStrobe, 1);
    checkOutput("t2_code", statusCode, 1);
    checkOutput("t2_noPacket", packetStrobe, 0);
    idle(1);
    checkOutput("t2_bad", badCount, 1);
    checkOutput("t2_pktCnt", pktCnt, 8);

    // Header with TLAST, then a clean packet
    applyStimulus(mkHdr(5'd3), 1'b1);
    checkOutput("t3_code", statusCode, 2);
    checkOutput("t3_noPacket", packetStrobe, 0);
    sendPacket(5'd3, mkData(5'd3, 8'd2));
    checkOutput("t3_next_code", statusCode, 0);
    checkOutput("t3_next_errors", payloadErrors, 0);
    idle(1);
    checkOutput("t3_good", goodCount, 9);
    checkOutput("t3_bad", badCount, 2);

    // Payload errors
    sendPacket(5'd4, mkData(5'd4, 8'd2) | 32'h8000_0000);
    checkOutput("t4_bit31_errors", payloadErrors, 5'b10000);
    checkOutput("t4_bit31_packet", packetStrobe, 1);
    idle(1);
    checkOutput("t4_bit31_bad", badCount, 3);
    sendPacket(5'd4, {3'b000, 5'd4, 16'hCACB, 8'd2});
    checkOutput("t4_pattern_errors", payloadErrors, 5'b00001);
    idle(1);
    checkOutput("t4_pattern_bad", badCount, 4);
    sendPacket(5'd4, mkData(5'd4, 8'd3));
    checkOutput("t4_cycle_errors", payloadErrors, 5'b00001);
    idle(1);
    checkOutput("t4_cycle_bad", badCount, 5);
    sendPacket(5'd5, mkData(5'd6, 8'd2));
    checkOutput("t4_index_errors", payloadErrors, 5'b00010);
    idle(1);
    checkOutput("t4_index_bad", badCount, 6);
    checkOutput("t4_good", goodCount, 9);

    // 254 more strobes (256 total) wrap the expected cycle to 0
    for (int i = 0; i < 254; i++) begin
      pulseCycle();
      if (i == 0) checkOutput("t5_lastCycle_first", lastCyclePackets, 1);
    end
    checkOutput("t5_lastCycle_empty", lastCyclePackets, 0);
    for (int p = 0; p < 2; p++) begin
      idle($urandom_range(0, 3));
      applyStimulus(mkHdr(5'd9), 1'b0);
      idle($urandom_range(0, 3));
      applyStimulus(mkData(5'd9, 8'd0), 1'b1);
      checkOutput("t5_wrap_code", statusCode, 0);
      checkOutput("t5_wrap_errors", payloadErrors, 0);
    end

    // Good report coinciding with a cycle strobe is checked against cycle 1
    sendPacket(5'd10, mkData(5'd10, 8'd1));
    newCycleStrobe = 1'b1;
    #1;
    checkOutput("coincide_errors", payloadErrors, 0);
    checkOutput("coincide_packet", packetStrobe, 1);
    @(posedge auroraUserClk);
    #1;
    newCycleStrobe = 1'b0;
    checkOutput("coincide_lastCycle", lastCyclePackets, 2);
    checkOutput("coincide_good", goodCount, 12);
    pulseCycle();
    checkOutput("coincide_newCycle", lastCyclePackets, 1);

    // Reset mid-packet drops the partial packet
    applyStimulus(mkHdr(5'd7), 1'b0);
    savedStatusCnt  = statusCnt;
    auroraUserRst_n = 1'b0;
    idle(1);
    auroraUserRst_n = 1'b1;
    idle(2);
    checkOutput("t6_no_strobe", statusCnt, savedStatusCnt);
    checkOutput("t6_good_cleared", goodCount, 0);
    checkOutput("t6_bad_cleared", badCount, 0);
    sendPacket(5'd7, mkData(5'd7, 8'd0));
    checkOutput("t6_code", statusCode, 0);
    checkOutput("t6_errors", payloadErrors, 0);
    checkOutput("t6_index", packetIndex, 7);
    idle(1);
    checkOutput("t6_good", goodCount, 1);
    checkOutput("t6_statusCnt", statusCnt, savedStatusCnt + 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
